// File: rtl/pc_call_sequencer_if.sv
// Bus between the control unit / program memory and the PC call sequencer.
// master: control side (drives start/stall/instr); slave: the sequencer.
interface pc_call_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int SP_W   = 3
);
  logic              start;
  logic              stall;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] addr;
  logic              exec_en;
  logic              busy;
  logic              halted;
  logic              fault;
  logic [1:0]        fault_code;
  logic [SP_W-1:0]   stack_level;

  modport master (
    output start, stall, instr,
    input  addr, exec_en, busy, halted, fault, fault_code, stack_level
  );

  modport slave (
    input  start, stall, instr,
    output addr, exec_en, busy, halted, fault, fault_code, stack_level
  );
endinterface

// File: rtl/pc_call_sequencer.sv
// Program-counter sequencer: fetch address, CALL/RET/STOP decode and a
// hardware return-address stack; other opcodes strobe exec_en for the datapath.
module pc_call_sequencer #(
  parameter int              ADDR_W      = 8,
  parameter int              DATA_W      = 16,
  parameter int              STACK_DEPTH = 4,
  parameter int              SP_W        = 3,
  parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}}
) (
  input logic                clk,
  input logic                rst_n,
  pc_call_sequencer_if.slave bus
);

  // Opcode values shared with the control unit's opcode table.
  localparam logic [4:0] OP_CALL = 5'b11000;
  localparam logic [4:0] OP_RET  = 5'b11001;
  localparam logic [4:0] OP_STOP = 5'b11111;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_OVER  = 2'b01;
  localparam logic [1:0] FC_UNDER = 2'b10;

  function automatic logic is_ctrl_op(input logic [4:0] op);
    return (op == OP_CALL) || (op == OP_RET) || (op == OP_STOP);
  endfunction

  logic [1:0]        state_r, state_nxt_s;
  logic [ADDR_W-1:0] pc_r, pc_nxt_s;
  logic [SP_W-1:0]   sp_r, sp_nxt_s;
  logic [1:0]        fcode_r, fcode_nxt_s;
  logic              push_s;
  logic [ADDR_W-1:0] ret_addr_s;
  logic [ADDR_W-1:0] stack_r [0:STACK_DEPTH-1];

  logic [4:0]        opcode_s;
  logic [ADDR_W-1:0] target_s;
  logic [SP_W-1:0]   sp_dec_s;

  assign opcode_s = bus.instr[DATA_W-1:DATA_W-5];
  assign target_s = bus.instr[ADDR_W-1:0];
  assign sp_dec_s = sp_r - SP_W'(1);

  // Operand bits between the opcode and the target field carry no meaning here.
  logic unused_instr_s;
  assign unused_instr_s = ^bus.instr[DATA_W-6:ADDR_W];

  // Return-address read mux: top of stack is entry sp-1.
  always_comb begin
    ret_addr_s = {ADDR_W{1'b0}};
    for (int i = 0; i < STACK_DEPTH; i++) begin
      ret_addr_s = ret_addr_s | (stack_r[i] & {ADDR_W{(SP_W'(i) == sp_dec_s)}});
    end
  end

  // Next-state, PC, stack pointer and fault code decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    sp_nxt_s    = sp_r;
    fcode_nxt_s = fcode_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE, HALT, FAULT: begin
        if (bus.start) begin
          state_nxt_s = RUN;
          pc_nxt_s    = START_ADDR;
          sp_nxt_s    = {SP_W{1'b0}};
          fcode_nxt_s = FC_NONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        if (bus.stall) begin
          state_nxt_s = RUN;
        end else begin
          case (opcode_s)
            OP_CALL: begin
              if (sp_r == SP_W'(STACK_DEPTH)) begin
                state_nxt_s = FAULT;
                fcode_nxt_s = FC_OVER;
              end else begin
                push_s   = 1'b1;
                sp_nxt_s = sp_r + SP_W'(1);
                pc_nxt_s = target_s;
              end
            end
            OP_RET: begin
              if (sp_r == {SP_W{1'b0}}) begin
                state_nxt_s = FAULT;
                fcode_nxt_s = FC_UNDER;
              end else begin
                sp_nxt_s = sp_dec_s;
                pc_nxt_s = ret_addr_s;
              end
            end
            OP_STOP: state_nxt_s = HALT;
            default: pc_nxt_s = pc_r + ADDR_W'(1);
          endcase
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      pc_r    <= START_ADDR;
      sp_r    <= {SP_W{1'b0}};
      fcode_r <= FC_NONE;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      sp_r    <= sp_nxt_s;
      fcode_r <= fcode_nxt_s;
    end
  end

  // Return-address storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (rst_n && push_s && (SP_W'(i) == sp_r)) begin
        stack_r[i] <= pc_r + ADDR_W'(1);
      end
    end
  end

  assign bus.addr        = pc_r;
  assign bus.busy        = (state_r == RUN);
  assign bus.halted      = (state_r == HALT);
  assign bus.fault       = (state_r == FAULT);
  assign bus.fault_code  = fcode_r;
  assign bus.stack_level = sp_r;
  assign bus.exec_en     = (state_r == RUN) && !bus.stall && !is_ctrl_op(opcode_s);

endmodule
